// File: rtl/mem_arbiter_if.sv
// One requester port of the two-port memory arbiter.
// master = requesting unit, slave = arbiter side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Port 0 = instruction fetch, port 1 = load/store unit.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      p0,
    mem_arbiter_if.slave      p1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic       acc;
    logic [1:0] req;
    logic [1:0] mask;
    logic [1:0] elig;
    logic       take;
    logic       win;

    assign acc = (state_q == S_ACC);
    assign req = {p1.req, p0.req};

    // Port holding the memory now cannot win the closing edge
    always_comb begin
        mask = 2'b11;
        if (acc) begin
            mask = id_q ? 2'b01 : 2'b10;
        end
        elig = req & mask;
        take = |elig;
        win  = 1'b0;
        unique case (elig)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = FAIR ? ~last_q : 1'b0;
            default: win = 1'b0;
        endcase
    end

    // Next access latch and read-return capture
    always_comb begin
        state_d  = take ? S_ACC : S_IDLE;
        last_d   = last_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        if (take) begin
            last_d  = win;
            id_d    = win;
            we_d    = win ? p1.we    : p0.we;
            addr_d  = win ? p1.addr  : p0.addr;
            wdata_d = win ? p1.wdata : p0.wdata;
        end

        if (acc && !we_q) begin
            rvalid_d[id_q] = 1'b1;
            if (id_q) begin
                rdata1_d = mem_read_data;
            end else begin
                rdata0_d = mem_read_data;
            end
        end
    end

    // State registers; reset wins over any pending access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Memory side is quiet outside an access; rst suppresses a landing write
    assign mem_address    = acc ? addr_q  : '0;
    assign mem_write_data = acc ? wdata_q : '0;
    assign mem_write_en   = acc & we_q & ~rst;
    assign mem_read_en    = acc & ~we_q;

    assign p0.gnt    = acc & ~id_q;
    assign p1.gnt    = acc & id_q;
    assign p0.rvalid = rvalid_q[0];
    assign p1.rvalid = rvalid_q[1];
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;

endmodule
